// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port instruction/data arbiter onto one single-port word memory
module mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_CAPTURE,
        S_ACK
    } state_t;

    // Wait counter reload value; unused when LATENCY is 0 because WAIT is skipped.
    localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    // Port identifiers: 0 = instruction, 1 = data.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic              port_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [31:0]       m_wdata_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    logic              grant_any;
    logic              grant_d;
    logic [ADDR_W-1:0] grant_addr;
    logic [ADDR_W-1:0] issue_addr;
    logic [31:0]       issue_wdata;

    // Upper address bits beyond the memory width are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr, d_addr};

    // Grant decision: single requester wins; on contention the port not served last wins.
    always_comb begin
        grant_any  = i_req | d_req;
        grant_d    = d_req & (~i_req | (last_q == PORT_I));
        grant_addr = grant_d ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
        // With LATENCY 0 the grant edge is also the edge entering ISSUE, so take the live values.
        issue_addr  = (state == S_IDLE) ? grant_addr : addr_q;
        issue_wdata = (state == S_IDLE) ? d_wdata    : wdata_q;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (grant_any) state_nx = (LATENCY > 0) ? S_WAIT : S_ISSUE;
            S_WAIT:    if (cnt == 4'd0) state_nx = S_ISSUE;
            S_ISSUE:   state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_ACK;
            S_ACK:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Grant bookkeeping, wait counter, memory request registers and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            port_q    <= PORT_I;
            last_q    <= PORT_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            m_addr_q  <= '0;
            m_wdata_q <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            if (state == S_IDLE && grant_any) begin
                port_q  <= grant_d;
                last_q  <= grant_d;
                addr_q  <= grant_addr;
                we_q    <= grant_d & d_we;
                wdata_q <= d_wdata;
                cnt     <= LAT_M1;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state_nx == S_ISSUE && state != S_ISSUE) begin
                m_addr_q  <= issue_addr;
                m_wdata_q <= issue_wdata;
            end
            if (state == S_CAPTURE) begin
                if (port_q == PORT_D) begin
                    d_rdata_q <= m_rdata;
                end else begin
                    i_rdata_q <= m_rdata;
                end
            end
        end
    end

    // Output decode from the current state and held registers.
    always_comb begin
        m_en    = (state == S_ISSUE);
        m_we    = (state == S_ISSUE) & we_q;
        m_addr  = m_addr_q;
        m_wdata = m_wdata_q;
        i_ack   = (state == S_ACK) & (port_q == PORT_I);
        d_ack   = (state == S_ACK) & (port_q == PORT_D);
        i_rdata = i_rdata_q;
        d_rdata = d_rdata_q;
        busy    = (state != S_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance 0: ADDR_W=10, LATENCY=0
    logic        rst0, i_req0, d_req0, d_we0;
    logic [31:0] i_addr0, d_addr0, d_wdata0;
    logic [31:0] i_rdata0, d_rdata0, m_wdata0, m_rdata0;
    logic        i_ack0, d_ack0, m_en0, m_we0, busy0;
    logic [9:0]  m_addr0;

    // Instance 1: ADDR_W=8, LATENCY=3
    logic        rst1, i_req1, d_req1, d_we1;
    logic [31:0] i_addr1, d_addr1, d_wdata1;
    logic [31:0] i_rdata1, d_rdata1, m_wdata1, m_rdata1;
    logic        i_ack1, d_ack1, m_en1, m_we1, busy1;
    logic [7:0]  m_addr1;

    mem_arbiter #(.ADDR_W(10), .LATENCY(0)) dut0 (
        .clk(clk), .reset(rst0),
        .i_req(i_req0), .i_addr(i_addr0), .i_rdata(i_rdata0), .i_ack(i_ack0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_rdata(d_rdata0), .d_ack(d_ack0),
        .m_en(m_en0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0),
        .m_rdata(m_rdata0), .busy(busy0)
    );

    mem_arbiter #(.ADDR_W(8), .LATENCY(3)) dut1 (
        .clk(clk), .reset(rst1),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1), .busy(busy1)
    );

    // Registered-read word memories behind each instance
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [256];
    int          en_pulses1 = 0;

    always @(posedge clk) begin
        if (m_en0) begin
            if (m_we0) mem0[m_addr0] <= m_wdata0;
            m_rdata0 <= mem0[m_addr0];
        end
    end

    always @(posedge clk) begin
        if (m_en1) begin
            if (m_we1) mem1[m_addr1] <= m_wdata1;
            m_rdata1 <= mem1[m_addr1];
            en_pulses1 <= en_pulses1 + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic g_ack(input int u, input logic isd);
        if (u == 0) return isd ? d_ack0 : i_ack0;
        return isd ? d_ack1 : i_ack1;
    endfunction

    function automatic logic [31:0] g_rdata(input int u, input logic isd);
        if (u == 0) return isd ? d_rdata0 : i_rdata0;
        return isd ? d_rdata1 : i_rdata1;
    endfunction

    function automatic logic g_men(input int u);
        return (u == 0) ? m_en0 : m_en1;
    endfunction

    function automatic logic g_mwe(input int u);
        return (u == 0) ? m_we0 : m_we1;
    endfunction

    function automatic logic [31:0] g_maddr(input int u);
        return (u == 0) ? {22'd0, m_addr0} : {24'd0, m_addr1};
    endfunction

    function automatic logic [31:0] g_all_or(input int u);
        if (u == 0)
            return i_rdata0 | d_rdata0 | m_wdata0 | {22'd0, m_addr0} |
                   {27'd0, i_ack0, d_ack0, m_en0, m_we0, busy0};
        return i_rdata1 | d_rdata1 | m_wdata1 | {24'd0, m_addr1} |
               {27'd0, i_ack1, d_ack1, m_en1, m_we1, busy1};
    endfunction

    task automatic set_req(input int u, input logic isd, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (u == 0) begin
            if (isd) begin d_req0 = v; d_we0 = we; d_addr0 = addr; d_wdata0 = wdata; end
            else begin i_req0 = v; i_addr0 = addr; end
        end else begin
            if (isd) begin d_req1 = v; d_we1 = we; d_addr1 = addr; d_wdata1 = wdata; end
            else begin i_req1 = v; i_addr1 = addr; end
        end
    endtask

    // One complete access from IDLE; checks issue cycle, memory request, ack cycle and data.
    task automatic access(input int u, input logic isd, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] maddr, input logic chk_rd,
                          input logic [31:0] rdata, input int lat, input int id);
        int          ack_c = -1;
        int          en_c  = -1;
        logic [31:0] en_a  = 32'd0;
        logic        en_w  = 1'b0;
        logic        other = 1'b0;
        logic [31:0] rd    = 32'd0;
        string       tag;
        tag = $sformatf("u%0d_v%0d", u, id);
        set_req(u, isd, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 24 && ack_c < 0; c++) begin
            tick();
            if (g_men(u) && en_c < 0) begin
                en_c = c;
                en_a = g_maddr(u);
                en_w = g_mwe(u);
            end
            if (g_ack(u, ~isd)) other = 1'b1;
            if (g_ack(u, isd)) begin
                ack_c = c;
                rd    = g_rdata(u, isd);
            end
        end
        set_req(u, isd, 1'b0, 1'b0, addr, wdata);
        chk({tag, "_ack_cycle"}, ack_c, lat + 3);
        chk({tag, "_men_cycle"}, en_c, lat + 1);
        chk({tag, "_maddr"}, en_a, maddr);
        chk({tag, "_mwe"}, {31'd0, en_w}, {31'd0, we});
        chk({tag, "_other_ack"}, {31'd0, other}, 32'd0);
        if (chk_rd) chk({tag, "_rdata"}, rd, rdata);
        tick();
        chk({tag, "_ack_pulse"}, {31'd0, g_ack(u, isd)}, 32'd0);
    endtask

    typedef struct {
        logic        isd;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] maddr;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [7];

    initial begin
        int p;
        logic dack_seen;

        for (int i = 0; i < 1024; i++) mem0[i] <= 32'd0;
        for (int i = 0; i < 256; i++) mem1[i] <= {4{8'(i)}};
        mem0[5] <= 32'hDEADBEEF;

        rst0 = 1'b0; rst1 = 1'b0;
        i_req0 = 0; d_req0 = 0; d_we0 = 0; i_addr0 = 0; d_addr0 = 0; d_wdata0 = 0;
        i_req1 = 0; d_req1 = 0; d_we1 = 0; i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0005, 32'h0,         32'h005, 1'b1, 32'hDEADBEEF};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h12345678,  32'h020, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h020, 1'b1, 32'h12345678};
        vt[3] = '{1'b0, 1'b0, 32'h0000_0420, 32'h0,         32'h020, 1'b1, 32'h12345678};
        vt[4] = '{1'b1, 1'b1, 32'hFFFF_FC07, 32'hA5A50001,  32'h007, 1'b0, 32'h0};
        vt[5] = '{1'b0, 1'b0, 32'h0000_0007, 32'h0,         32'h007, 1'b1, 32'hA5A50001};
        vt[6] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         32'h005, 1'b1, 32'hDEADBEEF};

        repeat (3) tick();
        chk("reset_zero_u0", g_all_or(0), 32'd0);
        chk("reset_zero_u1", g_all_or(1), 32'd0);
        rst0 = 1'b1; rst1 = 1'b1;
        tick();

        // Table-driven accesses on the zero-latency instance
        for (int k = 0; k < 7; k++)
            access(0, vt[k].isd, vt[k].we, vt[k].addr, vt[k].wdata, vt[k].maddr,
                   vt[k].chk_rd, vt[k].rdata, 0, k);
        chk("i_rdata_held", i_rdata0, 32'hA5A50001);

        // Contention from reset release: DATA, INSTR, DATA, acks 4 cycles apart
        rst0 = 1'b0;
        #1;
        chk("reset_zero_again_u0", g_all_or(0), 32'd0);
        i_req0 = 1; i_addr0 = 32'h5;
        d_req0 = 1; d_we0 = 0; d_addr0 = 32'h20;
        rst0 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("cont_d_ack_c%0d", c), {31'd0, d_ack0}, {31'd0, (c == 3 || c == 11)});
            chk($sformatf("cont_i_ack_c%0d", c), {31'd0, i_ack0}, {31'd0, (c == 7)});
            if (c == 3)  chk("cont_d_rdata", d_rdata0, 32'h12345678);
            if (c == 7)  chk("cont_i_rdata", i_rdata0, 32'hDEADBEEF);
        end
        i_req0 = 0; d_req0 = 0;
        tick();

        // LATENCY=3 single instruction read: busy 1..6, m_en at 4, ack at 6
        chk("lat3_busy_c0", {31'd0, busy1}, 32'd0);
        i_req1 = 1; i_addr1 = 32'h11;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("lat3_busy_c%0d", c), {31'd0, busy1}, {31'd0, (c <= 6)});
            chk($sformatf("lat3_men_c%0d", c), {31'd0, m_en1}, {31'd0, (c == 4)});
            chk($sformatf("lat3_iack_c%0d", c), {31'd0, i_ack1}, {31'd0, (c == 6)});
            if (c == 4) chk("lat3_maddr", {24'd0, m_addr1}, 32'h11);
            if (c == 6) begin
                chk("lat3_rdata", i_rdata1, 32'h11111111);
                i_req1 = 0;
            end
        end

        // Address truncation to 8 bits
        access(1, 1'b1, 1'b0, 32'h0000_0105, 32'h0, 32'h05, 1'b1, 32'h05050505, 3, 0);

        // Reset during WAIT of a write: aborted, nothing written, no ack
        p = en_pulses1;
        set_req(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h99999999);
        tick();
        chk("rstwait_busy", {31'd0, busy1}, 32'd1);
        tick();
        rst1 = 1'b0;
        #1;
        chk("rstwait_zero_async", g_all_or(1), 32'd0);
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        tick();
        chk("rstwait_zero_held", g_all_or(1), 32'd0);
        rst1 = 1'b1;
        dack_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (d_ack1) dack_seen = 1'b1;
        end
        chk("rstwait_no_ack", {31'd0, dack_seen}, 32'd0);
        chk("rstwait_no_men", en_pulses1 - p, 32'd0);
        chk("rstwait_mem", mem1[8'h30], 32'h30303030);
        access(1, 1'b1, 1'b0, 32'h30, 32'h0, 32'h30, 1'b1, 32'h30303030, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port access controller placing the processor's instruction-fetch port and data port onto one shared single-port word memory.
- Arbitrates between the two ports and inserts programmable wait states.
- Returns read data with a one-cycle ack pulse per port, matching the req/ack handshake the mips core expects.
- Sits between mips and a unified memory instance.

Parameters:
- ADDR_W, 10: memory word-address width; m_addr = port_addr[ADDR_W-1:0], higher address bits ignored.
- LATENCY, 0: wait-state cycles inserted between grant and memory issue (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction read request, level, held until i_ack.
- i_addr  in  32  instruction address.
- i_rdata  out  32  instruction read data, valid while i_ack=1, held until next i_ack.
- i_ack  out  1  one-cycle completion pulse, instruction port.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  1=write, 0=read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_rdata  out  32  data read data, valid while d_ack=1, held until next d_ack.
- d_ack  out  1  one-cycle completion pulse, data port.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable, qualified by m_en.
- m_addr  out  ADDR_W  memory word address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, registered; valid the cycle after m_en.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async), all outputs 0:
  - i_ack, d_ack, m_en, m_we, busy = 0.
  - i_rdata, d_rdata, m_addr, m_wdata = 0.
  - state = IDLE; wait counter = 0; last_grant = INSTR.
- States: IDLE, WAIT, ISSUE, CAPTURE, ACK.
- IDLE, grant decision on a rising edge:
  - Only one port requesting: grant it.
  - Both requesting: grant the port not in last_grant. The first contention after reset therefore goes to DATA.
  - On grant, register in the same edge: port id, addr[ADDR_W-1:0], we (forced 0 for INSTR), wdata. Update last_grant.
  - Next state: WAIT if LATENCY>0, else ISSUE.
  - No request: stay in IDLE.
- WAIT:
  - Counter loads LATENCY-1 on entry and decrements each cycle.
  - Go to ISSUE when counter = 0.
  - Occupies exactly LATENCY cycles.
- ISSUE, one cycle:
  - m_en=1; m_we=registered we; m_addr and m_wdata driven from registers.
  - A write commits at the closing edge.
  - m_en=0 in all other states. m_addr/m_wdata hold their last value.
- CAPTURE, one cycle:
  - m_rdata is latched into the granted port's rdata register at the closing edge.
  - On a write, the granted port's rdata is also loaded from m_rdata; its content is don't-care to the requester.
  - The other port's rdata is untouched.
- ACK, one cycle:
  - Granted port's ack=1, then go to IDLE.
- Timing:
  - Request sampled in IDLE at cycle 0 → ack high in cycle LATENCY+3.
  - Back-to-back throughput is one access per LATENCY+4 cycles.
- Requester rule: req is deasserted at the edge closing its ack cycle. A req still high in the following IDLE cycle is a new request.
- Only one access is in flight at a time. A non-granted port's req stays pending and is never dropped.
- Changes to port addr/wdata/we after grant have no effect on the in-flight access.
- Reset asserted mid-access:
  - In-flight access is aborted; no ack is produced.
  - A write already past ISSUE stays committed. A write not yet in ISSUE is not performed.

Test Plan:
- LATENCY=0; mem[5]=0xDEADBEEF; i_req=1, i_addr=5 at cycle 0 → m_en with m_addr=5 at cycle 1, i_ack=1 and i_rdata=0xDEADBEEF at cycle 3, d_ack stays 0.
- Data write then read: d_we=1, d_addr=0x20, d_wdata=0x12345678 → d_ack at cycle 3. Then d_we=0, same address → d_rdata=0x12345678 on the second d_ack.
- Contention: i_req and d_req both held from reset release → grants alternate DATA, INSTR, DATA; each ack 4 cycles apart; neither port starves.
- LATENCY=3: single i_req → m_en at cycle 4, i_ack at cycle 6; busy high in cycles 1-6.
- Address truncation, ADDR_W=8: d_addr=0x0000_0105 → m_addr=0x05.
- Reset pulse while in WAIT of a write (LATENCY=3) → no m_en pulse, no d_ack, memory unchanged; all outputs read 0 during reset; next request completes normally.
